cam_capture_ctrl: RTL
=====================

CAM_CAPTURE_CTRL -- requirements
Module: cam_capture_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 160, pixels per line.
REQ-002 SHALL have parameter IMG_H, default 120, lines per frame.
REQ-003 SHALL have parameter AW, default 15, frame-buffer address width.
REQ-004 SHALL have ports, in order:
- clk  input  1  system clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- CAM_pclk  input  1  camera pixel clock, sampled as data.
- CAM_vsync  input  1  camera vsync; high = frame blanking.
- CAM_href  input  1  camera href; high = valid line bytes.
- CAM_px_data  input  8  camera byte.
- start  input  1  one-cycle request to capture a frame.
- cont  input  1  continuous mode; sampled on start.
- mem_addr  output  AW  frame-buffer write address.
- mem_data  output  12  RGB444 pixel {R,G,B}.
- mem_we  output  1  one-cycle write strobe.
- busy  output  1  high in WAIT_VS or CAPTURE.
- done  output  1  one-cycle pulse at frame end.
- err  output  1  sticky error flag, cleared on start.
- frame_cnt  output  8  completed-frame count (see REQ-024).

Function
REQ-005 SHALL pass CAM_pclk, CAM_vsync and CAM_href through 2-flop synchronizers; CAM_px_data SHALL be delayed two clk cycles to stay aligned with them.
REQ-006 SHALL detect a pclk edge ("pe") on the cycle where synchronized pclk is 1 and its previous value was 0; clk SHALL be at least 4x CAM_pclk.
REQ-007 SHALL implement states IDLE, WAIT_VS, CAPTURE, DONE.
REQ-008 Transitions:
- IDLE->WAIT_VS on start.
- WAIT_VS->CAPTURE on a synchronized vsync falling edge.
- CAPTURE->DONE on a synchronized vsync rising edge.
- DONE->WAIT_VS if latched cont=1, else DONE->IDLE; DONE lasts one cycle.
REQ-009 start SHALL be ignored outside IDLE.
REQ-010 In CAPTURE on pe with href=1, bytes SHALL alternate. The first byte is held; its [3:0] is R. The second byte supplies G=[7:4], B=[3:0].
REQ-011 On the pe cycle of each second byte, SHALL assert mem_we on the following cycle only, with mem_data={R,G,B} and the current mem_addr.
REQ-012 mem_addr SHALL increment by 1 on the cycle after each write and SHALL be reset to 0 on entry to CAPTURE.
REQ-013 When a frame exceeds IMG_W*IMG_H pixels, writes SHALL be suppressed, mem_addr SHALL hold at IMG_W*IMG_H-1, and err SHALL be set.
REQ-014 On an href falling edge, the byte phase SHALL reset to "first". The following SHALL set err:
- a dangling odd byte (the byte is discarded);
- a line pixel count other than IMG_W.
REQ-015 The line counter SHALL increment on each href falling edge. If lines != IMG_H at the vsync rising edge, err SHALL be set.
REQ-016 href activity outside CAPTURE SHALL produce no writes.
REQ-017 done SHALL pulse high during the DONE cycle.
REQ-018 err SHALL clear on an accepted start; otherwise err is sticky.

Reset
REQ-019 On rst, state SHALL be IDLE and all of the following SHALL be 0:
- mem_addr, mem_data, mem_we, busy, done, err, frame_cnt;
- line/pixel counters, byte phase, latched cont;
- synchronizer flops.
REQ-020 rst mid-CAPTURE SHALL abort the frame with no further mem_we; the next frame SHALL require a new start.
REQ-021 rst SHALL dominate start on the same cycle.

Configuration
REQ-022 Macro CAM_CAPTURE_STATS_EN SHALL select frame statistics.
REQ-023 Without CAM_CAPTURE_STATS_EN, frame_cnt SHALL be constant 0.
REQ-024 With CAM_CAPTURE_STATS_EN, frame_cnt SHALL increment in DONE, wrap 255->0, and clear only on rst.

Verification
REQ-025 IMG_W=160, IMG_H=120, clk:pclk=4:1, start with cont=0, one 320-byte x 120-line frame -> 19200 mem_we, final addr 19199, one done, err=0, back to IDLE.
REQ-026 Byte pair 0x03,0xA5 -> mem_data=0x3A5 one cycle after the second-byte pe.
REQ-027 cont=1, three frames -> three done pulses, frame_cnt=3 with the macro, 0 without.
REQ-028 One line of 321 bytes -> err=1, that line writes 160 pixels, later lines are unaffected.
REQ-029 rst asserted after 50 lines -> mem_we stays 0 and state is IDLE; a following frame with no start -> no writes.
REQ-030 Frame of 122 lines -> writes stop at addr 19199, err=1, done pulses on the vsync rise.

Source files
------------

// File: rtl/cam_capture_ctrl.sv
// cam_capture_ctrl: captures RGB444 frames from an 8-bit DVP camera into a frame buffer; CAM_CAPTURE_STATS_EN enables frame_cnt.
// Latency: mem_we one clk after the detected pclk edge of each second byte (about 3-4 clk after the pin edge).
// Backpressure: none; the frame buffer must accept every mem_we strobe.
module cam_capture_ctrl #(
    parameter int IMG_W = 160,
    parameter int IMG_H = 120,
    parameter int AW    = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          CAM_pclk,
    input  logic          CAM_vsync,
    input  logic          CAM_href,
    input  logic [7:0]    CAM_px_data,
    input  logic          start,
    input  logic          cont,
    output logic [AW-1:0] mem_addr,
    output logic [11:0]   mem_data,
    output logic          mem_we,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [7:0]    frame_cnt
);
    localparam int            NPIX      = IMG_W * IMG_H;
    localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
    localparam logic [15:0]   LINE_PX   = 16'(IMG_W);
    localparam logic [15:0]   FRAME_LN  = 16'(IMG_H);

    typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, DONE} state_t;
    state_t state, state_nxt;

    logic       pclk_s1, pclk_s2, pclk_q;
    logic       vs_s1, vs_s2, vs_q;
    logic       href_s1, href_s2, href_q;
    logic [7:0] dat_d1, dat_d2;

    logic        phase, cont_q, full;
    logic [3:0]  r_hold;
    logic [15:0] line_px, line_cnt;

    logic pe, vs_fall, vs_rise, href_fall;
    logic start_ok, enter_cap, cap;

    always_ff @(posedge clk) begin
        if (rst) begin
            pclk_s1 <= 1'b0; pclk_s2 <= 1'b0; pclk_q <= 1'b0;
            vs_s1   <= 1'b0; vs_s2   <= 1'b0; vs_q   <= 1'b0;
            href_s1 <= 1'b0; href_s2 <= 1'b0; href_q <= 1'b0;
            dat_d1  <= 8'd0; dat_d2  <= 8'd0;
        end else begin
            pclk_s1 <= CAM_pclk;    pclk_s2 <= pclk_s1; pclk_q <= pclk_s2;
            vs_s1   <= CAM_vsync;   vs_s2   <= vs_s1;   vs_q   <= vs_s2;
            href_s1 <= CAM_href;    href_s2 <= href_s1; href_q <= href_s2;
            dat_d1  <= CAM_px_data; dat_d2  <= dat_d1;
        end
    end

    assign pe        = pclk_s2 & ~pclk_q;
    assign vs_fall   = vs_q & ~vs_s2;
    assign vs_rise   = ~vs_q & vs_s2;
    assign href_fall = href_q & ~href_s2;
    assign start_ok  = (state == IDLE) && start;
    assign enter_cap = (state == WAIT_VS) && vs_fall;
    assign cap       = (state == CAPTURE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:    if (start) state_nxt = WAIT_VS;
            WAIT_VS: begin
                busy = 1'b1;
                if (vs_fall) state_nxt = CAPTURE;
            end
            CAPTURE: begin
                busy = 1'b1;
                if (vs_rise) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = cont_q ? WAIT_VS : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr <= '0;
            mem_data <= 12'd0;
            mem_we   <= 1'b0;
            err      <= 1'b0;
            cont_q   <= 1'b0;
            phase    <= 1'b0;
            full     <= 1'b0;
            r_hold   <= 4'd0;
            line_px  <= 16'd0;
            line_cnt <= 16'd0;
        end else begin
            mem_we <= 1'b0;
            if (start_ok) begin
                cont_q <= cont;
                err    <= 1'b0;
            end
            if (enter_cap) begin
                mem_addr <= '0;
                phase    <= 1'b0;
                full     <= 1'b0;
                line_px  <= 16'd0;
                line_cnt <= 16'd0;
            end else begin
                if (mem_we && mem_addr != LAST_ADDR) mem_addr <= mem_addr + AW'(1);
                if (cap && pe && href_s2) begin
                    if (!phase) begin
                        r_hold <= dat_d2[3:0];
                        phase  <= 1'b1;
                    end else begin
                        phase <= 1'b0;
                        if (line_px != 16'hFFFF) line_px <= line_px + 16'd1;
                        // Once the last address is written, further pixels only flag an error.
                        if (full) begin
                            err <= 1'b1;
                        end else begin
                            mem_we   <= 1'b1;
                            mem_data <= {r_hold, dat_d2};
                            if (mem_addr == LAST_ADDR) full <= 1'b1;
                        end
                    end
                end
                if (cap && href_fall) begin
                    phase   <= 1'b0;
                    line_px <= 16'd0;
                    if (line_cnt != 16'hFFFF) line_cnt <= line_cnt + 16'd1;
                    if (phase || line_px != LINE_PX) err <= 1'b1;
                end
                if (cap && vs_rise && line_cnt != FRAME_LN) err <= 1'b1;
            end
        end
    end

`ifdef CAM_CAPTURE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst)                frame_cnt <= 8'd0;
        else if (state == DONE) frame_cnt <= frame_cnt + 8'd1;
    end
`else
    assign frame_cnt = 8'd0;
`endif

endmodule
